// File: rtl/smac_pkg.sv
// Shared precision codes, FSM state type and lane helpers for the SIMD MAC accumulator.
package smac_pkg;

   localparam logic [3:0] PREC_INT8  = 4'b0001;
   localparam logic [3:0] PREC_INT16 = 4'b0011;
   localparam logic [3:0] PREC_INT32 = 4'b0111;
   localparam logic [3:0] PREC_INT64 = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } smac_state_e;

   // Bytes per lane; unknown codes behave as INT64.
   function automatic int lane_bytes(input logic [3:0] prec);
      case (prec)
         PREC_INT8:  return 1;
         PREC_INT16: return 2;
         PREC_INT32: return 4;
         default:    return 8;
      endcase
   endfunction

   function automatic logic [63:0] sext_lane(input logic [63:0] v, input logic [3:0] prec);
      case (prec)
         PREC_INT8:  return {{56{v[7]}}, v[7:0]};
         PREC_INT16: return {{48{v[15]}}, v[15:0]};
         PREC_INT32: return {{32{v[31]}}, v[31:0]};
         default:    return v;
      endcase
   endfunction

endpackage

// File: rtl/smac_lane_acc.sv
// One lane slot starting at byte LANE_IDX: product register plus saturating/wrapping accumulator.
// The slot only contributes when LANE_IDX is aligned to the current lane width.
module smac_lane_acc
   import smac_pkg::*;
#(
   parameter int LANE_IDX = 0,
   parameter int SATURATE = 1
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        sclr,
   input  logic [3:0]  prec_i,
   input  logic        beat_v_i,
   input  logic        beat_first_i,
   input  logic        blk_start_i,
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  logic [63:0] c_i,
   output logic [63:0] acc_o,
   output logic        ovf_o
);

   logic signed [63:0]  a_ext_s, b_ext_s, acc_base_s;
   logic signed [127:0] prod_d, prod_q;
   logic signed [63:0]  c_d, c_q;
   logic                v_q, f_q;
   logic signed [129:0] sum_s, max_s, min_s;
   logic [63:0]         acc_d, acc_q;
   logic                ovf_d, ovf_q, lim_s;
   int                  n_s;

   // Full-width signed product of the sign-extended lane operands.
   always_comb begin
      a_ext_s = sext_lane(a_i, prec_i);
      b_ext_s = sext_lane(b_i, prec_i);
      c_d     = sext_lane(c_i, prec_i);
      prod_d  = 128'(a_ext_s) * 128'(b_ext_s);
   end

   // Accumulate with range check against the signed N-bit limits.
   always_comb begin
      n_s        = lane_bytes(prec_i) * 8;
      max_s      = (130'sd1 <<< (n_s - 1)) - 130'sd1;
      min_s      = -max_s - 130'sd1;
      acc_base_s = f_q ? 64'sd0 : sext_lane(acc_q, prec_i);
      sum_s      = 130'(acc_base_s) + 130'(prod_q) + (f_q ? 130'(c_q) : 130'sd0);
      lim_s      = (sum_s > max_s) || (sum_s < min_s);
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      if (blk_start_i) begin
         ovf_d = 1'b0;
      end else if (v_q && lim_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
      if (!v_q) begin
         acc_d = acc_q;
      end else if ((SATURATE != 0) && lim_s) begin
         acc_d = (sum_s < 130'sd0) ? min_s[63:0] : max_s[63:0];
      end else begin
         acc_d = sext_lane(sum_s[63:0], prec_i);
      end
   end

   // Product and accumulator pipeline registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         prod_q <= 128'sd0;
         c_q    <= 64'sd0;
         v_q    <= 1'b0;
         f_q    <= 1'b0;
         acc_q  <= 64'd0;
         ovf_q  <= 1'b0;
      end else if (sclr) begin
         prod_q <= 128'sd0;
         c_q    <= 64'sd0;
         v_q    <= 1'b0;
         f_q    <= 1'b0;
         acc_q  <= 64'd0;
         ovf_q  <= 1'b0;
      end else begin
         prod_q <= prod_d;
         c_q    <= c_d;
         v_q    <= beat_v_i;
         f_q    <= beat_first_i;
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
      end
   end

   assign acc_o = acc_q;
   assign ovf_o = ovf_q && ((LANE_IDX % lane_bytes(prec_i)) == 0);

endmodule

// File: rtl/smac_simd_acc.sv
// SIMD multiply-accumulate over ACC_DEPTH beats with selectable lane precision,
// optional chained partial sum and valid/ready handshakes on both sides.
module smac_simd_acc
   import smac_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int ACC_DEPTH = 4,
   parameter int SATURATE  = 1
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              sclr,
   input  logic [3:0]        select_precision,
   input  logic              active_chain,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_input,
   input  logic [DATA_W-1:0] weight,
   input  logic [DATA_W-1:0] res_mac_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] res_mac_n,
   output logic              overflow
);

   localparam int         NL       = DATA_W / 8;
   localparam logic [8:0] DEPTH_M1 = 9'(ACC_DEPTH - 1);

   smac_state_e       state_q, state_d;
   logic [8:0]        cnt_q, cnt_d;
   logic              rdy_q;
   logic [3:0]        prec_q;
   logic [DATA_W-1:0] a_q, b_q, c_q;
   logic              v1_q, f1_q;
   logic              accept_s, blk_start_s;
   logic [DATA_W+63:0] a_pad_s, b_pad_s, c_pad_s;
   logic [63:0]       acc_all_s [NL];
   logic [NL-1:0]     ovf_all_s;

   assign accept_s    = in_valid && in_ready && !sclr;
   assign blk_start_s = accept_s && ((state_q == IDLE) || (state_q == HOLD));

   // Handshake decode; rdy_q keeps in_ready low until the first edge out of reset.
   always_comb begin
      case (state_q)
         IDLE, ACCUM: in_ready = rdy_q;
         DRAIN:       in_ready = 1'b0;
         HOLD:        in_ready = rdy_q && out_ready;
         default:     in_ready = 1'b0;
      endcase
   end

   // Block sequencing; cnt_q counts beats in ACCUM and drain cycles in DRAIN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, HOLD: begin
            if (accept_s) begin
               state_d = (ACC_DEPTH == 1) ? DRAIN : ACCUM;
               cnt_d   = (ACC_DEPTH == 1) ? 9'd0 : 9'd1;
            end else if ((state_q == HOLD) && out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         ACCUM: begin
            if (accept_s && (cnt_q == DEPTH_M1)) begin
               state_d = DRAIN;
               cnt_d   = 9'd0;
            end else if (accept_s) begin
               cnt_d = cnt_q + 9'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         DRAIN: begin
            if (cnt_q == 9'd1) begin
               state_d = HOLD;
               cnt_d   = 9'd0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 9'd0;
         end
      endcase
      if (sclr) begin
         state_d = IDLE;
         cnt_d   = 9'd0;
      end else begin
         cnt_d = cnt_d;
      end
   end

   // FSM state, block attributes and input register stage.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         cnt_q   <= 9'd0;
         rdy_q   <= 1'b0;
         prec_q  <= 4'b0000;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         v1_q    <= 1'b0;
         f1_q    <= 1'b0;
      end else if (sclr) begin
         state_q <= IDLE;
         cnt_q   <= 9'd0;
         rdy_q   <= 1'b1;
         prec_q  <= 4'b0000;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         v1_q    <= 1'b0;
         f1_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= 1'b1;
         v1_q    <= accept_s;
         f1_q    <= blk_start_s;
         if (accept_s) begin
            a_q <= data_input;
            b_q <= weight;
         end
         if (blk_start_s) begin
            prec_q <= select_precision;
            c_q    <= active_chain ? res_mac_p : '0;
         end
      end
   end

   assign a_pad_s = {64'd0, a_q};
   assign b_pad_s = {64'd0, b_q};
   assign c_pad_s = {64'd0, c_q};

   for (genvar i = 0; i < NL; i++) begin : g_lane
      smac_lane_acc #(
         .LANE_IDX (i),
         .SATURATE (SATURATE)
      ) u_lane (
         .clk          (clk),
         .aresetn      (aresetn),
         .sclr         (sclr),
         .prec_i       (prec_q),
         .beat_v_i     (v1_q),
         .beat_first_i (f1_q),
         .blk_start_i  (blk_start_s),
         .a_i          (a_pad_s[i*8 +: 64]),
         .b_i          (b_pad_s[i*8 +: 64]),
         .c_i          (c_pad_s[i*8 +: 64]),
         .acc_o        (acc_all_s[i]),
         .ovf_o        (ovf_all_s[i])
      );
   end

   // Each result byte comes from the slot owning its lane at the current width.
   for (genvar j = 0; j < NL; j++) begin : g_pack
      localparam int B16 = j - (j % 2);
      localparam int B32 = j - (j % 4);
      localparam int B64 = j - (j % 8);
      logic [7:0] byte_s;
      always_comb begin
         case (prec_q)
            PREC_INT8:  byte_s = acc_all_s[j][7:0];
            PREC_INT16: byte_s = acc_all_s[B16][(j % 2)*8 +: 8];
            PREC_INT32: byte_s = acc_all_s[B32][(j % 4)*8 +: 8];
            default:    byte_s = acc_all_s[B64][(j % 8)*8 +: 8];
         endcase
      end
      assign res_mac_n[j*8 +: 8] = byte_s;
   end

   assign out_valid = (state_q == HOLD);
   assign overflow  = |ovf_all_s;

endmodule

// File: tb/tb_smac_simd_acc.sv
// Directed bench: saturating and wrapping instances share stimulus; expected values hand-computed.
module tb_smac_simd_acc;
   import smac_pkg::*;

   logic        clk = 1'b0;
   logic        aresetn, sclr, active_chain, in_valid, out_ready;
   logic [3:0]  select_precision;
   logic [63:0] data_input, weight, res_mac_p;
   logic        in_ready_s, out_valid_s, ovf_s;
   logic        in_ready_w, out_valid_w, ovf_w;
   logic [63:0] res_s, res_w;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   smac_simd_acc #(.DATA_W(64), .ACC_DEPTH(4), .SATURATE(1)) u_sat (
      .clk(clk), .aresetn(aresetn), .sclr(sclr), .select_precision(select_precision),
      .active_chain(active_chain), .in_valid(in_valid), .in_ready(in_ready_s),
      .data_input(data_input), .weight(weight), .res_mac_p(res_mac_p),
      .out_valid(out_valid_s), .out_ready(out_ready), .res_mac_n(res_s), .overflow(ovf_s));

   smac_simd_acc #(.DATA_W(64), .ACC_DEPTH(4), .SATURATE(0)) u_wrap (
      .clk(clk), .aresetn(aresetn), .sclr(sclr), .select_precision(select_precision),
      .active_chain(active_chain), .in_valid(in_valid), .in_ready(in_ready_w),
      .data_input(data_input), .weight(weight), .res_mac_p(res_mac_p),
      .out_valid(out_valid_w), .out_ready(out_ready), .res_mac_n(res_w), .overflow(ovf_w));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] p, input logic ch, input logic [63:0] pr,
                        input logic [63:0] d, input logic [63:0] w);
      select_precision = p;
      active_chain     = ch;
      res_mac_p        = pr;
      data_input       = d;
      weight           = w;
      in_valid         = 1'b1;
   endtask

   initial begin
      aresetn = 1'b0; sclr = 1'b0; active_chain = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      select_precision = PREC_INT64; data_input = 64'd0; weight = 64'd0; res_mac_p = 64'd0;
      #12;
      chk("rst_out_valid", {63'd0, out_valid_s}, 64'd0);
      chk("rst_res", res_s, 64'd0);
      chk("rst_ovf", {63'd0, ovf_s}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready_s}, 64'd0);
      #20;
      @(negedge clk);
      aresetn = 1'b1;
      tick();
      chk("post_rst_in_ready", {63'd0, in_ready_s}, 64'd1);

      // INT64 3*5 over four beats, latency check.
      drive(PREC_INT64, 1'b0, 64'd0, 64'd3, 64'd5);
      repeat (4) tick();
      in_valid = 1'b0;
      tick();
      chk("lat_k1_valid", {63'd0, out_valid_s}, 64'd0);
      tick();
      chk("lat_k2_valid", {63'd0, out_valid_s}, 64'd1);
      chk("int64_res", res_s, 64'd60);
      chk("int64_ovf", {63'd0, ovf_s}, 64'd0);

      // Back-pressure in HOLD with the next block's first beat already offered.
      drive(PREC_INT64, 1'b1, 64'd1, 64'd2, 64'd3);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_res", res_s, 64'd60);
         chk("hold_in_ready", {63'd0, in_ready_s}, 64'd0);
         chk("hold_valid", {63'd0, out_valid_s}, 64'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("hold_release_valid", {63'd0, out_valid_s}, 64'd0);
      active_chain = 1'b0;
      res_mac_p    = 64'd7;
      repeat (3) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("chain_valid", {63'd0, out_valid_s}, 64'd1);
      chk("chain_res", res_s, 64'd25);

      // INT8 saturate vs wrap.
      drive(PREC_INT8, 1'b0, 64'd0, 64'h7F7F7F7F7F7F7F7F, 64'h7F7F7F7F7F7F7F7F);
      repeat (4) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("int8_sat_res", res_s, 64'h7F7F7F7F7F7F7F7F);
      chk("int8_sat_ovf", {63'd0, ovf_s}, 64'd1);
      chk("int8_wrap_valid", {63'd0, out_valid_w}, 64'd1);
      chk("int8_wrap_res", res_w, 64'h0404040404040404);
      chk("int8_wrap_ovf", {63'd0, ovf_w}, 64'd1);

      // INT16 negative products, no overflow.
      drive(PREC_INT16, 1'b0, 64'd0, 64'hFFFEFFFEFFFEFFFE, 64'h0003000300030003);
      repeat (4) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("int16_res", res_s, 64'hFFE8FFE8FFE8FFE8);
      chk("int16_ovf", {63'd0, ovf_s}, 64'd0);
      chk("int16_wrap_res", res_w, 64'hFFE8FFE8FFE8FFE8);

      // INT32 negative saturation vs wrap.
      drive(PREC_INT32, 1'b0, 64'd0, 64'h8000000080000000, 64'h7FFFFFFF7FFFFFFF);
      repeat (4) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("int32_sat_res", res_s, 64'h8000000080000000);
      chk("int32_sat_ovf", {63'd0, ovf_s}, 64'd1);
      chk("int32_wrap_res", res_w, 64'd0);
      chk("int32_wrap_ovf", {63'd0, ovf_w}, 64'd1);

      // Precision change mid-block is ignored.
      drive(PREC_INT64, 1'b0, 64'd0, 64'd3, 64'd5);
      repeat (2) tick();
      select_precision = PREC_INT8;
      repeat (2) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("prec_switch_res", res_s, 64'd60);
      chk("prec_switch_ovf", {63'd0, ovf_s}, 64'd0);

      // sclr after two beats discards the block.
      drive(PREC_INT64, 1'b0, 64'd0, 64'd9, 64'd9);
      repeat (2) tick();
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      in_valid = 1'b0;
      chk("sclr_valid", {63'd0, out_valid_s}, 64'd0);
      chk("sclr_res", res_s, 64'd0);
      chk("sclr_ovf", {63'd0, ovf_s}, 64'd0);
      repeat (4) tick();
      chk("sclr_no_emit", {63'd0, out_valid_s}, 64'd0);
      drive(PREC_INT64, 1'b0, 64'd0, 64'd7, 64'd11);
      repeat (4) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("post_sclr_valid", {63'd0, out_valid_s}, 64'd1);
      chk("post_sclr_res", res_s, 64'd308);

      // Asynchronous reset mid-ACCUM.
      drive(PREC_INT64, 1'b0, 64'd0, 64'd5, 64'd5);
      repeat (2) tick();
      #2;
      aresetn  = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("arst_res", res_s, 64'd0);
      chk("arst_valid", {63'd0, out_valid_s}, 64'd0);
      chk("arst_ovf", {63'd0, ovf_s}, 64'd0);
      chk("arst_in_ready", {63'd0, in_ready_s}, 64'd0);
      repeat (3) tick();
      chk("arst_no_emit", {63'd0, out_valid_s}, 64'd0);
      @(negedge clk);
      aresetn = 1'b1;
      tick();
      chk("arst_ready_back", {63'd0, in_ready_s}, 64'd1);
      drive(PREC_INT64, 1'b0, 64'd0, 64'd4, 64'd4);
      repeat (4) tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("post_arst_valid", {63'd0, out_valid_s}, 64'd1);
      chk("post_arst_res", res_s, 64'd64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/smac_simd_acc.md
SMAC_SIMD_ACC -- requirements
Module: smac_simd_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 64, operand/result width; multiple of 64.
REQ-002 SHALL have parameter ACC_DEPTH, default 4, accepted beats per result block; range 1..256.
REQ-003 SHALL have parameter SATURATE, default 1; 1 saturates lane sums, 0 wraps them.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sclr, input, 1, synchronous clear, active high.
REQ-007 SHALL have port select_precision, input, 4, lane format code from smac_pkg.
REQ-008 SHALL have port active_chain, input, 1, adds res_mac_p into the block's first beat.
REQ-009 SHALL have port in_valid, input, 1, beat offered.
REQ-010 SHALL have port in_ready, output, 1, beat accepted when in_valid and in_ready are both high.
REQ-011 SHALL have ports data_input, weight and res_mac_p, input, DATA_W each: operands and chained partial sum.
REQ-012 SHALL have port out_valid, output, 1, res_mac_n holds a finished block.
REQ-013 SHALL have port out_ready, input, 1, downstream takes the result.
REQ-014 SHALL have port res_mac_n, output, DATA_W, packed lane results.
REQ-015 SHALL have port overflow, output, 1, at least one lane saturated or wrapped during the block.

Function
REQ-016 SHALL split operands into signed lanes: INT8 = 8b, INT16 = 16b, INT32 = 32b, INT64 = 64b; any other code acts as INT64.
REQ-017 SHALL sample select_precision and active_chain on the block's first accepted beat and ignore changes to them until the next block.
REQ-018 SHALL form each lane product at full 2N bits and add it into an N-bit lane accumulator, saturating to the signed N-bit min/max or wrapping per SATURATE.
REQ-019 SHALL, with active_chain sampled high, add the matching res_mac_p lane to the first beat's sum; otherwise the accumulator starts at 0.
REQ-020 SHALL be pipelined as input register, product register, accumulator register; after the last beat is accepted at edge k, res_mac_n/out_valid are valid after edge k+2.
REQ-021 SHALL use FSM states IDLE, ACCUM, DRAIN, HOLD.
REQ-022 SHALL move IDLE->ACCUM on first accepted beat, or IDLE->DRAIN when ACC_DEPTH=1.
REQ-023 SHALL move ACCUM->DRAIN on the ACC_DEPTH-th accepted beat and DRAIN->HOLD after 2 cycles.
REQ-024 SHALL move HOLD->IDLE on out_ready, or straight to ACCUM/DRAIN when a beat is accepted in the same cycle.
REQ-025 SHALL drive in_ready = 1 in IDLE/ACCUM, 0 in DRAIN, and out_ready in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-026 SHALL hold res_mac_n and overflow stable while out_valid && !out_ready.
REQ-027 SHALL make overflow sticky per block and clear it at block start.
REQ-028 SHALL, on sclr, return to IDLE, flush the pipeline and the beat counter, and zero res_mac_n/out_valid/overflow after that edge; sclr SHALL take priority over all events and beats offered during sclr are not accepted.

Reset
REQ-029 SHALL, while aresetn=0, force state IDLE, counter 0, pipeline 0, res_mac_n=0, out_valid=0, overflow=0 and in_ready=0; in_ready SHALL be 1 on the first edge after deassertion.
REQ-030 SHALL discard a partial block on reset mid-operation, with no result emitted.

Structure
REQ-031 SHALL take the precision codes INT8=4'b0001, INT16=4'b0011, INT32=4'b0111 and INT64=4'b1111, plus the FSM state enum, from package smac_pkg.
REQ-032 SHALL implement one lane sub-module smac_lane_acc (multiply, add, saturate/wrap for one 8-bit slice group), instantiated DATA_W/8 times and combined per precision.

Verification
REQ-033 INT64, ACC_DEPTH=4, chain off, data=3, weight=5 for 4 beats -> res_mac_n=60, overflow=0, out_valid after edge k+2.
REQ-034 INT8, all lanes 0x7F×0x7F for 4 beats -> SATURATE=1: every lane 0x7F, overflow=1; SATURATE=0: every lane 0x04.
REQ-035 INT64, active_chain=1, res_mac_p=1, data=2, weight=3 for 4 beats -> res_mac_n=25.
REQ-036 out_ready low for 5 cycles in HOLD -> res_mac_n stable and in_ready=0; then out_ready and in_valid high together -> next block starts that cycle with no beat lost.
REQ-037 Switch select_precision INT64->INT8 after beat 2 -> result still INT64; sclr after beat 2 -> out_valid stays 0 and a fresh 4-beat block gives the clean result.
REQ-038 aresetn pulsed low mid-ACCUM -> all outputs 0 immediately, no result emitted, and the next block is correct.
